// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default geometry, halt encoding and the sequential PC increment.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          MEM_DEPTH_DEFAULT = 256;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INCR           = 32'd4;

    // Word-align a redirect target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port for program loading and
// one asynchronous read port so the fetched word is valid with its PC.
module instr_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem_r [DEPTH];

    // Program load write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control, fetch
// counter and the instruction store feeding the IF/ID register.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
    parameter int          AW        = $clog2(MEM_DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          i_enable,
    input  logic          Start,
    input  logic          In_Branch,
    input  logic [31:0]   In_BranchTarget,
    input  logic          In_Jump,
    input  logic [31:0]   In_JumpTarget,
    input  logic          Mem_WrEn,
    input  logic [AW-1:0] Mem_WrAddr,
    input  logic [31:0]   Mem_WrData,
    output logic [31:0]   Out_Instruction,
    output logic [31:0]   Out_PCAdder,
    output logic [31:0]   Out_PC,
    output logic          Out_Halt,
    output logic [31:0]   Out_FetchCount
);

    logic [1:0]   rst_sync_r;
    logic         core_rst_n_s;
    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [31:0]  pc_r;
    logic [31:0]  next_pc_s;
    logic [31:0]  count_r;
    logic [31:0]  next_count_s;
    logic [31:0]  raw_word_s;
    logic [31:0]  pc_plus4_s;
    logic         advance_s;
    logic         mem_we_s;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign core_rst_n_s = rst_sync_r[1];
    assign advance_s    = Enable && i_enable;
    assign pc_plus4_s   = pc_r + PC_INCR;
    assign mem_we_s     = Mem_WrEn && (state_r == ST_IDLE);

    instr_mem #(
        .DEPTH(MEM_DEPTH),
        .AW   (AW)
    ) u_instr_mem (
        .clk    (Clock),
        .wr_en  (mem_we_s),
        .wr_addr(Mem_WrAddr),
        .wr_data(Mem_WrData),
        .rd_addr(pc_r[AW+1:2]),
        .rd_data(raw_word_s)
    );

    // State, PC and fetch counter registers.
    always_ff @(posedge Clock or negedge core_rst_n_s) begin
        if (!core_rst_n_s) begin
            state_r <= ST_IDLE;
            pc_r    <= 32'd0;
            count_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            pc_r    <= next_pc_s;
            count_r <= next_count_s;
        end
    end

    // Next PC selection: branch beats jump beats halt beats sequential.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        next_count_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!advance_s) begin
                    next_pc_s = pc_r;
                end else if (In_Branch) begin
                    next_pc_s    = align_word(In_BranchTarget);
                    next_count_s = count_r + 32'd1;
                end else if (In_Jump) begin
                    next_pc_s    = align_word(In_JumpTarget);
                    next_count_s = count_r + 32'd1;
                end else if (raw_word_s == HALT_WORD) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_pc_s    = pc_plus4_s;
                    next_count_s = count_r + 32'd1;
                end
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign Out_Instruction = (state_r == ST_RUN) ? raw_word_s : 32'd0;
    assign Out_PCAdder     = pc_plus4_s;
    assign Out_PC          = pc_r;
    assign Out_Halt        = (state_r == ST_HALT);
    assign Out_FetchCount  = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus
// randomized episodes compared against a behavioural fetch model.
module tb_instruction_fetch;

    localparam int          DEPTH = 256;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b0;
    logic        i_enable = 1'b0;
    logic        Start = 1'b0;
    logic        In_Branch = 1'b0;
    logic [31:0] In_BranchTarget = 32'd0;
    logic        In_Jump = 1'b0;
    logic [31:0] In_JumpTarget = 32'd0;
    logic        Mem_WrEn = 1'b0;
    logic [7:0]  Mem_WrAddr = 8'd0;
    logic [31:0] Mem_WrData = 32'd0;
    logic [31:0] Out_Instruction;
    logic [31:0] Out_PCAdder;
    logic [31:0] Out_PC;
    logic        Out_Halt;
    logic [31:0] Out_FetchCount;

    instruction_fetch dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Enable         (Enable),
        .i_enable       (i_enable),
        .Start          (Start),
        .In_Branch      (In_Branch),
        .In_BranchTarget(In_BranchTarget),
        .In_Jump        (In_Jump),
        .In_JumpTarget  (In_JumpTarget),
        .Mem_WrEn       (Mem_WrEn),
        .Mem_WrAddr     (Mem_WrAddr),
        .Mem_WrData     (Mem_WrData),
        .Out_Instruction(Out_Instruction),
        .Out_PCAdder    (Out_PCAdder),
        .Out_PC         (Out_PC),
        .Out_Halt       (Out_Halt),
        .Out_FetchCount (Out_FetchCount)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: 0 = waiting for start, 1 = fetching, 2 = stopped.
    logic [31:0] m_mem [DEPTH];
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input logic [31:0] pc);
        return m_mem[(pc / 4) % DEPTH];
    endfunction

    task automatic model_edge();
        if (m_mode == 0) begin
            if (Mem_WrEn) m_mem[Mem_WrAddr] = Mem_WrData;
            if (Start) m_mode = 1;
        end else if (m_mode == 1 && Enable && i_enable) begin
            if (In_Branch) begin
                m_pc = In_BranchTarget & 32'hFFFF_FFFC;
                m_cnt++;
            end else if (In_Jump) begin
                m_pc = In_JumpTarget & 32'hFFFF_FFFC;
                m_cnt++;
            end else if (m_word(m_pc) == HALT) begin
                m_mode = 2;
            end else begin
                m_pc = m_pc + 32'd4;
                m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    Out_PC, m_pc);
        check({tag, ".instr"}, Out_Instruction, (m_mode == 1) ? m_word(m_pc) : 32'd0);
        check({tag, ".adder"}, Out_PCAdder, m_pc + 32'd4);
        check({tag, ".halt"},  {31'd0, Out_Halt}, (m_mode == 2) ? 32'd1 : 32'd0);
        check({tag, ".count"}, Out_FetchCount, m_cnt);
    endtask

    task automatic step(input string tag);
        @(posedge Clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        Enable = 1'b1; i_enable = 1'b1; Start = 1'b0;
        In_Branch = 1'b0; In_Jump = 1'b0; Mem_WrEn = 1'b0;
    endtask

    // Asserts reset between edges, checks the asynchronous effect, then releases.
    task automatic do_reset(input string tag);
        quiet();
        #2 Reset = 1'b0;
        #1;
        m_mode = 0; m_pc = 32'd0; m_cnt = 32'd0;
        check_all(tag);
        repeat (2) @(posedge Clock);
        @(negedge Clock) Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
        Mem_WrEn = 1'b1; Mem_WrAddr = a; Mem_WrData = d;
        step("load");
        Mem_WrEn = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step("start");
        Start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_mode = 0; m_pc = 32'd0; m_cnt = 32'd0;
        quiet();
        repeat (3) @(posedge Clock);
        #1;
        check_all("reset");
        @(negedge Clock) Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = $urandom();
            if (w == HALT) w = 32'h0000_0013;
            mem_write(8'(i), w);
        end

        // Program load and run to halt.
        mem_write(8'd0, 32'h1111_1111);
        mem_write(8'd1, 32'h2222_2222);
        mem_write(8'd2, 32'h3333_3333);
        mem_write(8'd3, HALT);
        pulse_start();
        check("load.i0", Out_Instruction, 32'h1111_1111);
        step("run");
        check("load.i1", Out_Instruction, 32'h2222_2222);
        step("run");
        check("load.i2", Out_Instruction, 32'h3333_3333);
        step("run");
        step("run");
        check("load.halt", {31'd0, Out_Halt}, 32'd1);
        check("load.pc", Out_PC, 32'h0000_000C);
        check("load.count", Out_FetchCount, 32'd3);
        step("halted");
        check("halt.sticky", {31'd0, Out_Halt}, 32'd1);

        do_reset("rst_halt");
        mem_write(8'd3, 32'h4444_4444);
        pulse_start();

        // Stall at PC 0x04.
        step("run");
        Enable = 1'b0;
        In_Branch = 1'b1; In_BranchTarget = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check("stall.pc", Out_PC, 32'h0000_0004);
            check("stall.instr", Out_Instruction, 32'h2222_2222);
            check("stall.count", Out_FetchCount, 32'd1);
        end
        In_Branch = 1'b0;
        Enable = 1'b1;
        step("resume");
        check("resume.pc", Out_PC, 32'h0000_0008);

        // Branch beats jump; target alignment.
        In_Branch = 1'b1; In_BranchTarget = 32'h0000_0041;
        In_Jump = 1'b1;   In_JumpTarget = 32'h0000_0080;
        step("redir");
        check("redir.pc", Out_PC, 32'h0000_0040);
        check("redir.adder", Out_PCAdder, 32'h0000_0044);
        In_Branch = 1'b0; In_Jump = 1'b0;

        // Writes during RUN are ignored; wrap past the end of memory.
        Mem_WrEn = 1'b1; Mem_WrAddr = 8'd0; Mem_WrData = 32'hDEAD_BEEF;
        step("illegal_wr");
        Mem_WrEn = 1'b0;
        In_Jump = 1'b1; In_JumpTarget = 32'h0000_03FC;
        step("jump_end");
        In_Jump = 1'b0;
        check("wrap.pc0", Out_PC, 32'h0000_03FC);
        step("wrap");
        check("wrap.pc", Out_PC, 32'h0000_0400);
        check("wrap.word0", Out_Instruction, 32'h1111_1111);

        // Mid-run reset; memory survives it.
        do_reset("rst_run");
        pulse_start();
        check("rst.mem0", Out_Instruction, 32'h1111_1111);

        // Randomized episodes.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset("rst_ep");
            for (int k = 0; k < 8; k++) begin
                logic [31:0] w;
                w = ($urandom_range(3) == 0) ? HALT : $urandom();
                mem_write(8'($urandom_range(DEPTH - 1)), w);
            end
            pulse_start();
            for (int c = 0; c < 70; c++) begin
                Enable          = ($urandom_range(4) != 0);
                i_enable        = ($urandom_range(5) != 0);
                Start           = $urandom_range(1);
                In_Branch       = ($urandom_range(7) == 0);
                In_BranchTarget = $urandom_range(32'h0000_0FFF);
                In_Jump         = ($urandom_range(7) == 0);
                In_JumpTarget   = $urandom();
                Mem_WrEn        = $urandom_range(1);
                Mem_WrAddr      = 8'($urandom_range(DEPTH - 1));
                Mem_WrData      = $urandom();
                step("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit instruction words.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, meaning the instruction encoding that stops fetch.
REQ-003 The block SHALL have port Clock, input, width 1, the single system clock; all state updates on posedge.
REQ-004 The block SHALL have port Reset, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port Enable, input, width 1: hazard-unit PC write enable; 0 means stall.
REQ-006 The block SHALL have port i_enable, input, width 1: debug step enable; PC advances only when Enable && i_enable.
REQ-007 The block SHALL have port Start, input, width 1: a one-cycle pulse moving IDLE to RUN.
REQ-008 The block SHALL have ports In_Branch (input, 1) and In_BranchTarget (input, 32): taken-branch redirect and its byte address.
REQ-009 The block SHALL have ports In_Jump (input, 1) and In_JumpTarget (input, 32): jump redirect and its byte address.
REQ-010 The block SHALL have ports Mem_WrEn (input, 1), Mem_WrAddr (input, log2(MEM_DEPTH)) and Mem_WrData (input, 32): the debug program-load port, word addressed.
REQ-011 The block SHALL have port Out_Instruction, output, width 32: the instruction at PC, fed to the IF/ID register.
REQ-012 The block SHALL have port Out_PCAdder, output, width 32: PC+4, fed to the IF/ID register.
REQ-013 The block SHALL have ports Out_PC (output, 32, current PC) and Out_Halt (output, 1, high in HALT).
REQ-014 The block SHALL have port Out_FetchCount, output, width 32: the number of PC advances since reset.

Function
REQ-015 The block SHALL implement states IDLE, RUN and HALT, with transitions IDLE->RUN on Start and RUN->HALT on halt detect; HALT SHALL be left only by Reset.
REQ-016 The block SHALL write Mem_WrData to word Mem_WrAddr on a clock edge only in IDLE with Mem_WrEn=1; Mem_WrEn SHALL be ignored in RUN and HALT.
REQ-017 The block SHALL read instruction memory asynchronously at word index PC[log2(MEM_DEPTH)+1:2], so Out_Instruction is valid in the same cycle as PC (zero latency).
REQ-018 The block SHALL drive Out_Instruction to 32'd0 (NOP) in IDLE and HALT, and to the raw memory word in RUN.
REQ-019 The block SHALL compute Out_PCAdder = PC + 4 combinationally, with 32-bit modulo wrap-around.
REQ-020 In RUN, with Enable && i_enable, next PC SHALL be selected with priority In_Branch > In_Jump > PC+4.
REQ-021 The block SHALL force bits [1:0] of any redirect target to 00 when loading it into PC.
REQ-022 The block SHALL hold PC when Enable && i_enable is 0; a redirect asserted during a stall SHALL be lost (upstream re-asserts).
REQ-023 In RUN with Enable && i_enable, if the raw memory word equals HALT_WORD, the block SHALL move to HALT at the next edge, hold PC at the halt address, and leave the count unchanged.
REQ-024 A redirect in the same cycle as halt detect SHALL take priority: PC loads the target and no halt occurs.
REQ-025 The block SHALL increment Out_FetchCount by 1 on every PC update in RUN, wrapping at 2^32.
REQ-026 The block SHALL take the word index modulo MEM_DEPTH when PC points beyond memory; no error is flagged.

Reset
REQ-027 On Reset=0 (asynchronous), the block SHALL set PC=0, state IDLE, Out_FetchCount=0, Out_Halt=0 and Out_Instruction=0.
REQ-028 Reset SHALL NOT clear instruction memory contents.
REQ-029 Reset asserted mid-RUN or in HALT SHALL return the block to IDLE immediately; reset release SHALL be synchronous to Clock.

Structure
REQ-030 Package fetch_pkg SHALL hold the state encoding (IDLE/RUN/HALT), HALT_WORD, MEM_DEPTH default and the PC increment constant 4.
REQ-031 The block SHALL contain sub-module instr_mem: MEM_DEPTH x 32, one synchronous write port and one asynchronous read port; the PC register, FSM and counter SHALL live in instruction_fetch.

Verification
REQ-032 Load test: load words 0..3 = 0x11111111, 0x22222222, 0x33333333, HALT_WORD, then pulse Start -> Out_Instruction 0x11111111, 0x22222222, 0x33333333 on successive cycles; Out_Halt=1 after the fourth; PC=0x0C; Out_FetchCount=3.
REQ-033 Stall test: Enable=0 for 3 cycles at PC=0x04 -> PC, Out_Instruction and count are held; they resume at 0x08 after release.
REQ-034 Redirect test: In_Branch=1 with target 0x41 and In_Jump=1 with target 0x80 in the same cycle -> next PC=0x40; Out_PCAdder=0x44.
REQ-035 Reset test: assert Reset=0 mid-RUN, between clock edges -> PC=0, IDLE, Out_Instruction=0 without waiting for a clock edge; memory contents are unchanged when read back after the next Start.
REQ-036 Illegal-write and wrap test: Mem_WrEn in RUN leaves memory unchanged; a jump to 0x3FC followed by a step -> PC=0x400, which reads word 0.
